// File: rtl/reservation_station_param.sv
// Out-of-order reservation station: holds waiting ops, snoops CDB_N
// result buses, issues the oldest ready entry over valid/ready.
//
// Ports:
//   clk, rst (sync active-high), ena (global freeze), in_flush
//   in_disp_* / out_disp_ready : dispatch from decode
//   in_cdb_valid/tag/data      : packed CDB broadcast ports
//   out_issue_valid / in_issue_ready / out_* : issue to execution unit
//   out_free_count             : number of free entries
module reservation_station_param #(
    parameter int RS_DEPTH = 8,
    parameter int DATA_W   = 32,
    parameter int ROB_W    = 4,
    parameter int OP_W     = 6,
    parameter int CDB_N    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          in_flush,
    input  logic                          in_disp_valid,
    output logic                          out_disp_ready,
    input  logic [OP_W-1:0]               in_op,
    input  logic [ROB_W-1:0]              in_Qj,
    input  logic [ROB_W-1:0]              in_Qk,
    input  logic [DATA_W-1:0]             in_Vj,
    input  logic [DATA_W-1:0]             in_Vk,
    input  logic [DATA_W-1:0]             in_imm,
    input  logic [DATA_W-1:0]             in_pc,
    input  logic [ROB_W-1:0]              in_rd_rob,
    input  logic                          in_has_rd_dest,
    input  logic [CDB_N-1:0]              in_cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]        in_cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]       in_cdb_data,
    output logic                          out_issue_valid,
    input  logic                          in_issue_ready,
    output logic [OP_W-1:0]               out_op,
    output logic [DATA_W-1:0]             out_Vj,
    output logic [DATA_W-1:0]             out_Vk,
    output logic [DATA_W-1:0]             out_imm,
    output logic [DATA_W-1:0]             out_pc,
    output logic [ROB_W-1:0]              out_rob_tag,
    output logic [$clog2(RS_DEPTH+1)-1:0] out_free_count
);

    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] busy_q;
    logic [OP_W-1:0]     op_q   [RS_DEPTH];
    logic [ROB_W-1:0]    qj_q   [RS_DEPTH];
    logic [ROB_W-1:0]    qk_q   [RS_DEPTH];
    logic [DATA_W-1:0]   vj_q   [RS_DEPTH];
    logic [DATA_W-1:0]   vk_q   [RS_DEPTH];
    logic [DATA_W-1:0]   imm_q  [RS_DEPTH];
    logic [DATA_W-1:0]   pc_q   [RS_DEPTH];
    logic [ROB_W-1:0]    dst_q  [RS_DEPTH];
    // older_q[i][j] = 1 when entry i was dispatched before entry j
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
    logic [CW-1:0]       free_q;

    logic [DATA_W:0]     wk_j [RS_DEPTH];
    logic [DATA_W:0]     wk_k [RS_DEPTH];
    logic [DATA_W:0]     fw_j;
    logic [DATA_W:0]     fw_k;
    logic [RS_DEPTH-1:0] ready;
    logic [RS_DEPTH-1:0] blocked;
    logic [IW-1:0]       sel_idx;
    logic [IW-1:0]       free_idx;
    logic                any_ready;
    logic                disp_fire;
    logic                load;
    logic                issue_fire;

    // Returns {hit, data}; scanning high to low lets the lowest port win.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = CDB_N - 1; k >= 0; k--) begin
            if (in_cdb_valid[k] && tag != '0 &&
                in_cdb_tag[k*ROB_W +: ROB_W] == tag)
                r = {1'b1, in_cdb_data[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        fw_j = cdb_lookup(in_Qj);
        fw_k = cdb_lookup(in_Qk);
        for (int i = 0; i < RS_DEPTH; i++) begin
            wk_j[i] = cdb_lookup(qj_q[i]);
            wk_k[i] = cdb_lookup(qk_q[i]);
        end
    end

    always_comb begin
        ready = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            ready[i] = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
    end

    // An entry is blocked when some older entry is also ready.
    always_comb begin
        blocked = '0;
        sel_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++)
                if (ready[j] && older_q[j][i])
                    blocked[i] = 1'b1;
            if (ready[i] && !blocked[i])
                sel_idx = IW'(i);
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!busy_q[i])
                free_idx = IW'(i);
    end

    assign any_ready      = |ready;
    assign out_disp_ready = free_q != '0;
    assign out_free_count = free_q;
    assign disp_fire      = in_disp_valid && out_disp_ready && !in_flush;
    assign load           = !out_issue_valid || in_issue_ready;
    assign issue_fire     = load && any_ready && !in_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q          <= '0;
            free_q          <= CW'(RS_DEPTH);
            out_issue_valid <= 1'b0;
            out_op          <= '0;
            out_Vj          <= '0;
            out_Vk          <= '0;
            out_imm         <= '0;
            out_pc          <= '0;
            out_rob_tag     <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                op_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                imm_q[i]   <= '0;
                pc_q[i]    <= '0;
                dst_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (ena) begin
            if (in_flush) begin
                busy_q          <= '0;
                free_q          <= CW'(RS_DEPTH);
                out_issue_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (busy_q[i] && wk_j[i][DATA_W]) begin
                        qj_q[i] <= '0;
                        vj_q[i] <= wk_j[i][DATA_W-1:0];
                    end
                    if (busy_q[i] && wk_k[i][DATA_W]) begin
                        qk_q[i] <= '0;
                        vk_q[i] <= wk_k[i][DATA_W-1:0];
                    end
                end

                if (load) begin
                    out_issue_valid <= any_ready;
                    if (any_ready) begin
                        out_op          <= op_q[sel_idx];
                        out_Vj          <= vj_q[sel_idx];
                        out_Vk          <= vk_q[sel_idx];
                        out_imm         <= imm_q[sel_idx];
                        out_pc          <= pc_q[sel_idx];
                        out_rob_tag     <= dst_q[sel_idx];
                        busy_q[sel_idx] <= 1'b0;
                    end
                end

                // Free entry is never the one being issued, so the busy
                // writes above and below cannot collide.
                if (disp_fire) begin
                    busy_q[free_idx] <= 1'b1;
                    op_q[free_idx]   <= in_op;
                    imm_q[free_idx]  <= in_imm;
                    pc_q[free_idx]   <= in_pc;
                    dst_q[free_idx]  <= in_has_rd_dest ? in_rd_rob : '0;
                    qj_q[free_idx]   <= fw_j[DATA_W] ? '0 : in_Qj;
                    vj_q[free_idx]   <= fw_j[DATA_W] ? fw_j[DATA_W-1:0] : in_Vj;
                    qk_q[free_idx]   <= fw_k[DATA_W] ? '0 : in_Qk;
                    vk_q[free_idx]   <= fw_k[DATA_W] ? fw_k[DATA_W-1:0] : in_Vk;
                    older_q[free_idx] <= '0;
                    for (int j = 0; j < RS_DEPTH; j++)
                        older_q[j][free_idx] <= busy_q[j];
                end

                free_q <= free_q + CW'(issue_fire) - CW'(disp_fire);
            end
        end
    end

endmodule

// File: tb/tb_reservation_station_param.sv
// Bench for reservation_station_param: vector table plus hand
// sequences, with an issue scoreboard checked at the falling edge.
module tb_reservation_station_param;

    localparam int RS = 8;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int OW = 6;
    localparam int CN = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic            in_flush;
    logic            in_disp_valid;
    logic            out_disp_ready;
    logic [OW-1:0]   in_op;
    logic [RW-1:0]   in_Qj, in_Qk;
    logic [DW-1:0]   in_Vj, in_Vk, in_imm, in_pc;
    logic [RW-1:0]   in_rd_rob;
    logic            in_has_rd_dest;
    logic [CN-1:0]   in_cdb_valid;
    logic [CN*RW-1:0] in_cdb_tag;
    logic [CN*DW-1:0] in_cdb_data;
    logic            out_issue_valid;
    logic            in_issue_ready;
    logic [OW-1:0]   out_op;
    logic [DW-1:0]   out_Vj, out_Vk, out_imm, out_pc;
    logic [RW-1:0]   out_rob_tag;
    logic [3:0]      out_free_count;

    always #5 clk = ~clk;

    reservation_station_param #(
        .RS_DEPTH(RS), .DATA_W(DW), .ROB_W(RW), .OP_W(OW), .CDB_N(CN)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_flush(in_flush),
        .in_disp_valid(in_disp_valid), .out_disp_ready(out_disp_ready),
        .in_op(in_op), .in_Qj(in_Qj), .in_Qk(in_Qk),
        .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm), .in_pc(in_pc),
        .in_rd_rob(in_rd_rob), .in_has_rd_dest(in_has_rd_dest),
        .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag),
        .in_cdb_data(in_cdb_data),
        .out_issue_valid(out_issue_valid), .in_issue_ready(in_issue_ready),
        .out_op(out_op), .out_Vj(out_Vj), .out_Vk(out_Vk),
        .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag),
        .out_free_count(out_free_count)
    );

    typedef struct packed {
        logic [OW-1:0] op;
        logic [DW-1:0] vj;
        logic [DW-1:0] vk;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [RW-1:0] tag;
    } iss_t;

    typedef struct {
        logic [OW-1:0] op;
        logic [RW-1:0] qj, qk;
        logic [DW-1:0] vj, vk, imm, pc;
        logic [RW-1:0] rd;
        logic          has;
        logic [1:0]    cv;
        logic [RW-1:0] ct0, ct1;
        logic [DW-1:0] cd0, cd1;
        logic [DW-1:0] evj, evk;
        logic [RW-1:0] etag;
    } vec_t;

    iss_t   sb[$];
    iss_t   mon_a, mon_e;
    vec_t   vt[7];
    int     n_pass = 0;
    int     n_tot  = 0;
    logic [143:0] outs, snap;

    assign outs = {out_issue_valid, out_disp_ready, out_free_count, out_op,
                   out_Vj, out_Vk, out_imm, out_pc, out_rob_tag};

    task automatic chk(input string nm, input logic [143:0] act,
                       input logic [143:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [OW-1:0] op, input logic [RW-1:0] qj,
                        input logic [RW-1:0] qk, input logic [DW-1:0] vj,
                        input logic [DW-1:0] vk, input logic [DW-1:0] imm,
                        input logic [DW-1:0] pc, input logic [RW-1:0] rd,
                        input logic has);
        in_disp_valid  = 1'b1;
        in_op = op; in_Qj = qj; in_Qk = qk; in_Vj = vj; in_Vk = vk;
        in_imm = imm; in_pc = pc; in_rd_rob = rd; in_has_rd_dest = has;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [RW-1:0] t0,
                       input logic [RW-1:0] t1, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1);
        in_cdb_valid = v;
        in_cdb_tag   = {t1, t0};
        in_cdb_data  = {d1, d0};
    endtask

    // A handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && ena && !in_flush && out_issue_valid && in_issue_ready) begin
            mon_a = '{out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag};
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL issue_unexpected: got %h, required none", mon_a);
            end else begin
                mon_e = sb.pop_front();
                chk("issue", 144'(mon_a), 144'(mon_e));
            end
        end
    end

    initial begin
        vt[0] = '{6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 32'd0, 32'h100, 4'd3, 1'b1,
                  2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 32'd5, 32'd7, 4'd3};
        vt[1] = '{6'd2, 4'd0, 4'd6, 32'd1, 32'd2, 32'd4, 32'h104, 4'd4, 1'b1,
                  2'b01, 4'd6, 4'd0, 32'hAA, 32'd0, 32'd1, 32'hAA, 4'd4};
        vt[2] = '{6'd3, 4'd0, 4'd0, 32'd9, 32'd8, 32'd0, 32'h108, 4'd9, 1'b0,
                  2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 32'd9, 32'd8, 4'd0};
        vt[3] = '{6'd4, 4'd5, 4'd7, 32'd0, 32'd0, 32'd1, 32'h10C, 4'd5, 1'b1,
                  2'b11, 4'd5, 4'd7, 32'h11, 32'h22, 32'h11, 32'h22, 4'd5};
        vt[4] = '{6'd5, 4'd3, 4'd0, 32'd0, 32'd6, 32'd2, 32'h110, 4'd6, 1'b1,
                  2'b11, 4'd3, 4'd3, 32'h100, 32'h200, 32'h100, 32'd6, 4'd6};
        vt[5] = '{6'h3F, 4'd0, 4'd0, 32'hFFFF_FFFF, 32'h8000_0000,
                  32'hFFFF_FFFF, 32'hFFFF_FFFC, 4'd15, 1'b1,
                  2'b00, 4'd0, 4'd0, 32'd0, 32'd0,
                  32'hFFFF_FFFF, 32'h8000_0000, 4'd15};
        vt[6] = '{6'd7, 4'd0, 4'd0, 32'h1234, 32'h5678, 32'd3, 32'h118, 4'd8,
                  1'b1, 2'b10, 4'd0, 4'd0, 32'd0, 32'hDEAD,
                  32'h1234, 32'h5678, 4'd8};

        rst = 1'b1; ena = 1'b1; in_flush = 1'b0; in_disp_valid = 1'b0;
        in_op = '0; in_Qj = '0; in_Qk = '0; in_Vj = '0; in_Vk = '0;
        in_imm = '0; in_pc = '0; in_rd_rob = '0; in_has_rd_dest = 1'b0;
        in_issue_ready = 1'b0;
        cdb(2'b00, 0, 0, 0, 0);
        step(); step();
        rst = 1'b0;
        chk("rst_valid", 144'(out_issue_valid), 144'(0));
        chk("rst_free", 144'(out_free_count), 144'(8));
        chk("rst_dready", 144'(out_disp_ready), 144'(1));
        chk("rst_data", 144'({out_op, out_Vj, out_Vk, out_imm, out_pc,
                               out_rob_tag}), 144'(0));

        in_issue_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            disp(vt[i].op, vt[i].qj, vt[i].qk, vt[i].vj, vt[i].vk,
                 vt[i].imm, vt[i].pc, vt[i].rd, vt[i].has);
            cdb(vt[i].cv, vt[i].ct0, vt[i].ct1, vt[i].cd0, vt[i].cd1);
            sb.push_back('{vt[i].op, vt[i].evj, vt[i].evk, vt[i].imm,
                           vt[i].pc, vt[i].etag});
            step();
            in_disp_valid = 1'b0;
            cdb(2'b00, 0, 0, 0, 0);
            chk("tbl_wait_valid", 144'(out_issue_valid), 144'(0));
            chk("tbl_wait_free", 144'(out_free_count), 144'(7));
            step();
            chk("tbl_valid", 144'(out_issue_valid), 144'(1));
            chk("tbl_tag", 144'(out_rob_tag), 144'(vt[i].etag));
            chk("tbl_free", 144'(out_free_count), 144'(8));
        end

        // Older entry waits on CDB; younger ready entry overtakes it.
        disp(6'd10, 4'd4, 4'd0, 32'd0, 32'd1, 32'd0, 32'h200, 4'd1, 1'b1);
        step();
        disp(6'd11, 4'd0, 4'd0, 32'd2, 32'd3, 32'd0, 32'h204, 4'd2, 1'b1);
        step();
        in_disp_valid = 1'b0;
        chk("wk_none", 144'(out_issue_valid), 144'(0));
        sb.push_back('{6'd11, 32'd2, 32'd3, 32'd0, 32'h204, 4'd2});
        sb.push_back('{6'd10, 32'h55, 32'd1, 32'd0, 32'h200, 4'd1});
        cdb(2'b10, 4'd0, 4'd4, 32'd0, 32'h55);
        step();
        cdb(2'b00, 0, 0, 0, 0);
        chk("wk_first", 144'(out_rob_tag), 144'(2));
        step();
        chk("wk_second", 144'(out_rob_tag), 144'(1));
        chk("wk_vj", 144'(out_Vj), 144'(32'h55));
        step();
        chk("wk_empty", 144'(out_issue_valid), 144'(0));

        // Fill under back-pressure, freeze with ena, then drain in order.
        in_issue_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            disp(6'(20 + i), 4'd0, 4'd0, 32'(i), 32'(i * 3), 32'd0,
                 32'(32'h300 + i * 4), 4'(i + 1), 1'b1);
            sb.push_back('{6'(20 + i), 32'(i), 32'(i * 3), 32'd0,
                           32'(32'h300 + i * 4), 4'(i + 1)});
            step();
        end
        in_disp_valid = 1'b0;
        chk("full_free", 144'(out_free_count), 144'(0));
        chk("full_dready", 144'(out_disp_ready), 144'(0));
        chk("full_head", 144'(out_rob_tag), 144'(1));
        disp(6'd40, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h400, 4'd14, 1'b1);
        step();
        in_disp_valid = 1'b0;
        chk("full_refuse", 144'(out_free_count), 144'(0));
        snap = outs;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_hold", outs, snap);
        end
        ena = 1'b0;
        in_issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ena_hold", outs, snap);
        end
        ena = 1'b1;
        disp(6'd41, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h404, 4'd15, 1'b1);
        step();
        in_disp_valid = 1'b0;
        chk("full_issue_refuse", 144'(out_free_count), 144'(1));
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("drain_done", 144'(sb.size()), 144'(0));
        step();
        chk("drain_valid", 144'(out_issue_valid), 144'(0));
        chk("drain_free", 144'(out_free_count), 144'(8));

        // Flush with one op held in the issue register and five waiting.
        in_issue_ready = 1'b0;
        disp(6'd50, 4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'h500, 4'd1, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            disp(6'(51 + i), 4'(9 + i), 4'd0, 32'd0, 32'd0, 32'd0,
                 32'(32'h504 + i * 4), 4'(2 + i), 1'b1);
            step();
        end
        chk("pre_flush_free", 144'(out_free_count), 144'(3));
        chk("pre_flush_valid", 144'(out_issue_valid), 144'(1));
        disp(6'd60, 4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h600, 4'd7, 1'b1);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        in_disp_valid = 1'b0;
        chk("flush_valid", 144'(out_issue_valid), 144'(0));
        chk("flush_free", 144'(out_free_count), 144'(8));
        chk("flush_dready", 144'(out_disp_ready), 144'(1));
        in_issue_ready = 1'b1;
        cdb(2'b11, 4'd9, 4'd10, 32'h1, 32'h2);
        step();
        cdb(2'b11, 4'd11, 4'd12, 32'h3, 32'h4);
        step();
        cdb(2'b01, 4'd13, 4'd0, 32'h5, 32'h0);
        step();
        cdb(2'b00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_issue", 144'(out_issue_valid), 144'(0));
        end
        chk("sb_empty", 144'(sb.size()), 144'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
Parametrised out-of-order reservation station that sits between the decoder/dispatch stage and one execution unit (ALU or branch unit). It holds up to RS_DEPTH waiting instructions and snoops CDB_N result broadcast buses to wake up pending operands. It issues the oldest ready entry over a valid/ready handshake. It adds several things to the previous station: an N-port CDB, same-cycle dispatch forwarding, age-ordered issue, back-pressure from the execution unit, and a misprediction flush.

Parameters:
RS_DEPTH, 8, number of entries (2..32)
DATA_W, 32, operand/imm/pc width
ROB_W, 4, ROB tag width; tag 0 = "no dependency / no destination"
OP_W, 6, operation code width
CDB_N, 2, number of CDB broadcast ports

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ena  in  1  global enable; 0 freezes all state and outputs
in_flush  in  1  misprediction flush; clears every entry
in_disp_valid  in  1  dispatch request
out_disp_ready  out  1  at least one free entry (registered-state based)
in_op  in  OP_W  operation
in_Qj, in_Qk  in  ROB_W each  source producer tags (0 = value valid)
in_Vj, in_Vk  in  DATA_W each  source values
in_imm, in_pc  in  DATA_W each  immediate, instruction PC
in_rd_rob  in  ROB_W  destination ROB tag
in_has_rd_dest  in  1  0 forces stored dest tag to 0
in_cdb_valid  in  CDB_N  per-port broadcast valid
in_cdb_tag  in  CDB_N*ROB_W  packed tags, port k at [k*ROB_W +: ROB_W]
in_cdb_data  in  CDB_N*DATA_W  packed data
out_issue_valid  out  1  issue slot holds an instruction
in_issue_ready  in  1  execution unit accepts
out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag  out  matching widths  issued instruction
out_free_count  out  $clog2(RS_DEPTH+1)  number of free entries

Behaviour:
- Reset (rst=1 at posedge): all busy=0, all tags=0, age matrix cleared, out_issue_valid=0, all out_* data=0, out_free_count=RS_DEPTH. rst overrides ena and flush.
- ena=0: no state changes. Upstream guarantees in_cdb_valid=0 and in_disp_valid=0 while ena=0.
- Entry state: busy, op, Qj/Qk, Vj/Vk, imm, pc, dest tag. Ordering is held in an RS_DEPTH×RS_DEPTH age matrix (older[i][j]).
- Wakeup: for every busy entry and each port k with in_cdb_valid[k] and tag!=0 equal to Qj (resp. Qk), set Qj<=0 and Vj<=data on the next edge.
  - Two ports carrying the same tag is illegal. The lowest port index wins.
- Dispatch: accepted when in_disp_valid & out_disp_ready & ~in_flush.
  - Fills the lowest-index free entry. Sets busy, and marks it younger than all currently busy entries.
  - Same-cycle forwarding: if in_Qj/in_Qk matches a valid CDB tag this cycle, store tag 0 and the CDB data instead of in_V*.
- Ready: busy & Qj==0 & Qk==0, evaluated on registered state. An entry woken or dispatched at edge t is issue-eligible from cycle t+1.
- Select: the oldest ready entry (no older ready entry in the age matrix).
- Issue register:
  - Load: when out_issue_valid==0 or in_issue_ready==1, and a ready entry exists, load the selected entry into out_*, set out_issue_valid=1, and clear that entry's busy bit on the same edge.
  - No ready entry: if no ready entry exists under the same condition, out_issue_valid<=0 and out_* hold their previous values.
  - Stall: while out_issue_valid=1 and in_issue_ready=0, out_* are stable.
  - Throughput: 1 issue per cycle.
- Latency: dispatch with ready operands at edge t → out_issue_valid at edge t+1 (empty station, no stall).
- out_disp_ready = (free count > 0) from registered state. A full station with a same-cycle issue still refuses dispatch.
- Simultaneous dispatch and issue of different entries in one cycle is supported. out_free_count is updated by +issue −dispatch.
- Flush: on the next edge, all busy=0, out_issue_valid=0, out_free_count=RS_DEPTH. Any same-cycle dispatch and wakeup are discarded.
- Tag 0 on CDB is never matched.

Test Plan:
- Reset then dispatch op=ADD, Qj=Qk=0, Vj=5, Vk=7, rd_rob=3 at cycle 1 → out_issue_valid=1 at cycle 2 with Vj=5, Vk=7, out_rob_tag=3; out_free_count returns to RS_DEPTH.
- Dispatch entry A (Qj=4), then entry B (ready); CDB port1 tag=4 data=0x55 → B issues first; A issues the next cycle with Vj=0x55.
- Dispatch with in_Qk=6 while CDB port0 broadcasts tag 6 data=0xAA the same cycle → entry stores Qk=0, issues with Vk=0xAA one cycle later.
- Fill all 8 entries with ready ops and hold in_issue_ready=0 → out_disp_ready=0, out_free_count=0, out_* stable. Release ready → entries issue strictly in dispatch order, one per cycle.
- Five entries waiting plus one in the issue register, assert in_flush → next cycle out_issue_valid=0, out_free_count=8, and a later CDB broadcast of their tags produces no issue.
- in_has_rd_dest=0 with in_rd_rob=9 → issued out_rob_tag=0; with ena=0 held for 3 cycles mid-stall, all outputs are unchanged.
